// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: one result bit per cycle (shift-add multiply,
// restoring divide) over 32 RUN cycles, then a single DONE cycle that writes back.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd_in,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic        write_EN,
  output logic [4:0]  write_address,
  output logic [31:0] write_data
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic        neg_q;
  logic [31:0] acc_q;
  logic [31:0] lo_q;
  logic [31:0] opb_q;
  logic        busy_q;
  logic        done_q;
  logic        we_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  // Operand conditioning at the start edge: magnitudes plus the result sign
  logic        a_sgn_in;
  logic        b_sgn_in;
  logic        neg_a_in;
  logic        neg_b_in;
  logic        neg_in;
  logic [31:0] abs_a_in;
  logic [31:0] abs_b_in;

  always_comb begin
    a_sgn_in = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
               (funct3 == OP_DIV)  || (funct3 == OP_REM);
    b_sgn_in = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
    neg_a_in = a_sgn_in & operand_a[31];
    neg_b_in = b_sgn_in & operand_b[31];
    abs_a_in = neg32(operand_a, neg_a_in);
    abs_b_in = neg32(operand_b, neg_b_in);
    case (funct3)
      OP_MULH:   neg_in = neg_a_in ^ neg_b_in;
      OP_MULHSU: neg_in = neg_a_in;
      // A zero divisor must leave the all-ones quotient unnegated
      OP_DIV:    neg_in = (neg_a_in ^ neg_b_in) & (operand_b != 32'd0);
      OP_REM:    neg_in = neg_a_in;
      default:   neg_in = 1'b0;
    endcase
  end

  // Iteration step and final result from the step's next values
  logic [32:0] mul_sum;
  logic [32:0] div_rs;
  logic        div_ge;
  logic [31:0] acc_d;
  logic [31:0] lo_d;
  logic [63:0] prod;
  logic [31:0] result_d;

  always_comb begin
    mul_sum = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opb_q : 32'd0)};
    div_rs  = {acc_q, lo_q[31]};
    div_ge  = div_rs[32] | (div_rs[31:0] >= opb_q);
    if (op_q[2]) begin
      acc_d = div_ge ? (div_rs[31:0] - opb_q) : div_rs[31:0];
      lo_d  = {lo_q[30:0], div_ge};
    end else begin
      acc_d = mul_sum[32:1];
      lo_d  = {mul_sum[0], lo_q[31:1]};
    end
    prod     = neg64({acc_d, lo_d}, neg_q);
    result_d = 32'd0;
    case (op_q)
      OP_MUL:                       result_d = prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[63:32];
      OP_DIV, OP_DIVU:              result_d = neg32(lo_d, neg_q);
      default:                      result_d = neg32(acc_d, neg_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      neg_q   <= 1'b0;
      acc_q   <= 32'd0;
      lo_q    <= 32'd0;
      opb_q   <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          we_q   <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= 5'd0;
            op_q    <= funct3;
            rd_q    <= rd_in;
            neg_q   <= neg_in;
            acc_q   <= 32'd0;
            lo_q    <= abs_a_in;
            opb_q   <= abs_b_in;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            we_q    <= (rd_q != 5'd0);
            waddr_q <= rd_q;
            wdata_q <= result_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign write_EN      = we_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model with a per-cycle output
// compare, plus directed RV32M vectors with hand-computed results.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic        write_EN;
  logic [4:0]  write_address;
  logic [31:0] write_data;

  int n_chk  = 0;
  int n_fail = 0;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .rd_in(rd_in),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
    .write_EN(write_EN), .write_address(write_address), .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result straight from RV32M arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    int          ia;
    int          ib;
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Model: an accepted start completes in the 33rd cycle after its edge
  int          m_age   = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_res   = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [4:0]  m_rd    = 5'd0;
  logic [4:0]  m_waddr = 5'd0;

  always @(posedge clk) begin
    if (!reset) begin
      m_valid = 1'b1;
      m_age   = 0;
      m_wdata = 32'd0;
      m_waddr = 5'd0;
    end else if (m_age == 0) begin
      if (start) begin
        m_age = 1;
        m_res = ref_res(funct3, operand_a, operand_b);
        m_rd  = rd_in;
      end
    end else if (m_age == 33) begin
      m_age = 0;
    end else begin
      m_age++;
      if (m_age == 33) begin
        m_wdata = m_res;
        m_waddr = m_rd;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {31'd0, busy}, {31'd0, m_age != 0});
      chk("done", {31'd0, done}, {31'd0, m_age == 33});
      chk("write_EN", {31'd0, write_EN}, {31'd0, (m_age == 33) && (m_rd != 5'd0)});
      chk("write_address", {27'd0, write_address}, {27'd0, m_waddr});
      chk("write_data", write_data, m_wdata);
    end
  end

  // Issue one op at the current negedge, scramble inputs, wait for done
  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int n;
    start = 1'b1; funct3 = f; operand_a = a; operand_b = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom;
    funct3 = 3'($urandom); rd_in = 5'($urandom);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, 33);
    chk({nm, " result"}, write_data, exp);
    chk({nm, " model"}, ref_res(f, a, b), exp);
    @(negedge clk);
  endtask

  initial begin
    int n_done;
    int n_we;
    reset = 1'b0; start = 1'b0; funct3 = 3'd0; rd_in = 5'd0;
    operand_a = 32'd0; operand_b = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset write_data", write_data, 32'd0);
    chk("reset write_address", {27'd0, write_address}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    do_op("MUL",      3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
    do_op("MULH",     3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000);
    do_op("MULHU",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE);
    do_op("MULHSU",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF);
    do_op("MULH neg", 3'd1, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF);
    do_op("DIV",      3'd4, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD);
    do_op("REM",      3'd6, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF);
    do_op("DIVU",     3'd5, 32'd100,      32'd7,        5'd8,  32'd14);
    do_op("REMU",     3'd7, 32'd100,      32'd7,        5'd9,  32'd2);
    do_op("DIVU by0", 3'd5, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF);
    do_op("REM by0",  3'd6, 32'd5,        32'd0,        5'd11, 32'd5);
    do_op("DIV negby0", 3'd4, 32'hFFFFFFF8, 32'd0,      5'd12, 32'hFFFFFFFF);
    do_op("DIV ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000);
    do_op("REM ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0);
    do_op("MUL rd0",  3'd0, 32'd3,        32'd4,        5'd0,  32'd12);

    // start during RUN is ignored
    start = 1'b1; funct3 = 3'd5; operand_a = 32'd100; operand_b = 32'd7; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int i = 1; i <= 45; i++) begin
      if (done) n_done++;
      if (i == 5) begin start = 1'b1; funct3 = 3'd0; operand_a = 32'd9; operand_b = 32'd9; end
      if (i == 6) start = 1'b0;
      @(negedge clk);
    end
    chk("ignored start done count", n_done, 1);
    chk("ignored start result", write_data, 32'd14);

    // reset at RUN cycle 10 aborts, and dominates a simultaneous start
    start = 1'b1; funct3 = 3'd0; operand_a = 32'd6; operand_b = 32'd7; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    reset = 1'b0; start = 1'b1;
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    n_we = 0;
    for (int i = 0; i < 40; i++) begin
      if (write_EN || done) n_we++;
      @(negedge clk);
    end
    chk("abort no write", n_we, 0);
    chk("abort write_data", write_data, 32'd0);

    do_op("MUL after reset", 3'd0, 32'd6, 32'd7, 5'd9, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001: Parameters: none; the datapath is fixed at 32 bits to match the register file ports.
REQ-002: clk  input  1  single clock; all state updates on posedge clk.
REQ-003: reset  input  1  synchronous, active-low reset; reset==0 at a posedge clears all state.
REQ-004: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005: funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006: rd_in  input  5  destination register index for the result.
REQ-007: operand_a  input  32  rs1 value, driven from register-file read_data1.
REQ-008: operand_b  input  32  rs2 value, driven from register-file read_data2.
REQ-009: busy  output  1  high while an operation is in flight (RUN or DONE).
REQ-010: done  output  1  one-cycle completion pulse.
REQ-011: write_EN  output  1  register-file write enable.
REQ-012: write_address  output  5  register-file write index.
REQ-013: write_data  output  32  register-file write data (result).

Function
REQ-014: The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015: IDLE -> RUN on posedge with start=1; funct3, rd_in, operand_a and operand_b are latched on that edge, and later input changes are ignored.
REQ-016: RUN SHALL last exactly 32 cycles, processing one bit per cycle (shift-add multiply, restoring divide), counted by a 5-bit counter; RUN -> DONE after the 32nd iteration.
REQ-017: DONE SHALL last exactly one cycle and then return to IDLE; the unconditional latency from the start edge to the done cycle is 33 cycles, for every op and operand value.
REQ-018: start SHALL be ignored in RUN and DONE; the earliest back-to-back start is the first IDLE cycle after DONE.
REQ-019: Signed ops SHALL operate on absolute values and negate the result when required. Sign rules:
- MULH: both operands signed.
- MULHSU: a signed, b unsigned.
- DIV quotient sign = sign(a) XOR sign(b).
- REM sign = sign(a).
REQ-020: MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] of the full 64-bit product.
REQ-021: Divide by zero:
- DIV and DIVU SHALL return 0xFFFFFFFF.
- REM and REMU SHALL return operand_a.
- Latency remains 33 cycles.
REQ-022: Signed overflow (0x80000000 / 0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-023: In DONE: done=1 and write_address=latched rd; write_EN=1 only if rd!=0, else write_EN=0 while done still pulses.
REQ-024: write_EN and done SHALL be 0 in IDLE and RUN.
REQ-025: write_data SHALL present the result in DONE and hold the last result until the next DONE.
REQ-026: busy SHALL be 1 from the cycle after the start edge through the DONE cycle, and 0 otherwise.

Reset
REQ-027: With reset=0 at a posedge, the following SHALL all be cleared to 0: state=IDLE, busy, done, write_EN, write_address, write_data, counter and internal registers.
REQ-028: Reset in RUN or DONE SHALL abort the operation with no write_EN pulse; reset dominates a simultaneous start.
REQ-029: Reset has no asynchronous effect; outputs change only at a clock edge.

Verification
REQ-030: MUL a=7, b=0xFFFFFFFD, rd=5 -> 33 cycles after start: done=1, write_EN=1, write_address=5, write_data=0xFFFFFFEB.
REQ-031: Multiply-high cases:
- MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-033: Boundary cases:
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Each completes at exactly 33 cycles.
REQ-034: Handshake and reset cases:
- start pulsed at RUN cycle 5 -> ignored, single done.
- reset=0 at RUN cycle 10 -> busy=0 on the next cycle, no write_EN.
- A new start after reset completes normally.
REQ-035: rd_in=0 with MUL 3*4 -> done pulses, write_EN stays 0, write_data=12.
